// File: rtl/cpu_pkg.sv
// Shared core definitions: instruction width, fetch FSM states.
// Used by the fetch front end and its prefetch queue.
package cpu_pkg;

  localparam int unsigned INSTR_WIDTH    = 16;
  localparam int unsigned DEF_ADDR_WIDTH = 32;

  localparam logic [INSTR_WIDTH-1:0] THUMB_NOP = 16'hBF00;

  typedef enum logic {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: synchronous FIFO with push/pop/clear and occupancy count.
// Storage resets to zero so the head reads as zero out of reset.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = INSTR_WIDTH + DEF_ADDR_WIDTH,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q;
  logic [PW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);

  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);

  // Pointer and occupancy update; clear drops every entry.
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (do_push && !clear_i) begin
      mem_q[wr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch front end: PC, credit-limited memory requests, prefetch queue, flush.
// IFETCH_BYPASS_EN: forward a response straight to the decoder when queue empty.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned           FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_ready,
  input  logic                   imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   redirect,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [ADDR_WIDTH-1:0]  instr_pc
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned EW = INSTR_WIDTH + ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PC_MASK = ~ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(2);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] fpc_q, fpc_d;
  logic [ADDR_WIDTH-1:0] rpc_q, rpc_d;
  logic [CW-1:0]         out_q, out_d;
  logic [CW-1:0]         fifo_cnt;
  logic [CW:0]           credit;
  logic                  fifo_empty;
  logic [EW-1:0]         head;
  logic                  accept;
  logic                  resp;
  logic                  keep;
  logic                  push;
  logic                  pop;
  logic                  byp;

  assign credit    = {1'b0, fifo_cnt} + {1'b0, out_q};
  assign imem_req  = !reset && (state_q == FETCH) &&
                     (credit < (CW+1)'(FIFO_DEPTH));
  assign imem_addr = fpc_q;
  assign accept    = imem_req && imem_ready;

  // Responses with nothing outstanding belong to a pre-reset request.
  assign resp = imem_rvalid && (out_q != '0);
  assign keep = resp && (state_q == FETCH) && !redirect;
  assign pop  = instr_valid && instr_ready;

`ifdef IFETCH_BYPASS_EN
  assign byp  = keep && fifo_empty;
  assign push = keep && !(byp && instr_ready);
`else
  assign byp  = 1'b0;
  assign push = keep;
`endif

  assign instr_valid = !fifo_empty || byp;
  assign instruction = byp ? imem_rdata : head[EW-1:ADDR_WIDTH];
  assign instr_pc    = byp ? rpc_q : head[ADDR_WIDTH-1:0];

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (redirect),
    .wdata_i ({imem_rdata, rpc_q}),
    .rdata_o (head),
    .count_o (fifo_cnt),
    .empty_o (fifo_empty)
  );

  // Next PCs, outstanding count and FETCH/FLUSH transitions.
  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    rpc_d   = rpc_q;
    out_d   = out_q + CW'(accept) - CW'(resp);
    if (accept) fpc_d = fpc_q + PC_STEP;
    if (keep)   rpc_d = rpc_q + PC_STEP;
    unique case (state_q)
      FETCH: state_d = FETCH;
      FLUSH: if (out_d == '0) state_d = FETCH;
      default: state_d = FETCH;
    endcase
    if (redirect) begin
      fpc_d   = redirect_pc & PC_MASK;
      rpc_d   = redirect_pc & PC_MASK;
      state_d = (out_d != '0) ? FLUSH : FETCH;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      fpc_q   <= RESET_PC & PC_MASK;
      rpc_q   <= RESET_PC & PC_MASK;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      rpc_q   <= rpc_d;
      out_q   <= out_d;
    end
  end

endmodule
